z80_wait_state_ctrl: RTL and testbench
======================================

// Module: z80_wait_state_ctrl
// PURPOSE
// - Sequences Z80 bus cycles: inserts programmable wait states per cycle type (M1, memory, I/O) by driving WAIT_n.
// - Holds slow-I/O cycles (SD/SPI port window) in wait until the peripheral acks, with a timeout watchdog.
// - Sits between the CPU strobes and the peripheral flip-flop/latch fabric. Its cycle_active output gates their register enables.
// PARAMETERS
// - M1_WAITS      1      wait clocks for opcode fetch (MREQ_n & M1_n low)
// - MEM_WAITS     0      wait clocks for other memory cycles
// - IO_WAITS      2      wait clocks for I/O cycles and INTA (IORQ_n & M1_n low)
// - SLOW_BASE     8'h68  base of the slow I/O port window
// - SLOW_MASK     8'hFC  io_addr bits compared against SLOW_BASE
// - TMO_CYCLES    255    max clocks spent in SLOW_WAIT (1..255)
// PORTS
// - clk          in   1  system clock, all inputs synchronous to it
// - reset        in   1  synchronous, active-high reset
// - mreq_n       in   1  Z80 MREQ_n, pre-synchronised
// - iorq_n       in   1  Z80 IORQ_n, pre-synchronised
// - m1_n         in   1  Z80 M1_n, pre-synchronised
// - io_addr      in   8  Z80 A[7:0], valid while iorq_n low
// - slow_ack     in   1  slow peripheral done; level, sampled each clk
// - tmo_clr      in   1  one-clock pulse, clears timeout_flag
// - wait_n       out  1  to Z80 WAIT_n, registered
// - slow_req     out  1  request to slow peripheral, registered
// - cycle_active out  1  high from cycle start until strobes released
// - timeout_flag out  1  sticky: a slow cycle ended by timeout
// BEHAVIOUR
// - Reset (sync): state=IDLE, wait_n=1, slow_req=0, cycle_active=0, timeout_flag=0, counters=0, strobe history=1 (high).
// - Cycle start: mreq_n or iorq_n low this clk and high the previous clk (registered history). A one-clock start pulse.
// - Type priority at start:
//   - iorq_n&m1_n low -> INTA (IO_WAITS)
//   - else mreq_n&m1_n low -> M1
//   - else mreq_n -> MEM
//   - else iorq_n -> IO
// - slow_sel is latched at start: IO type and (io_addr & SLOW_MASK)==SLOW_BASE. INTA is never slow.
// - States: IDLE, COUNT, SLOW_WAIT, HOLD.
// - IDLE:
//   - On start, cycle_active=1 next clk.
//   - If N>0 -> COUNT with cnt=N and wait_n=0 next clk.
//   - Else if slow_sel -> SLOW_WAIT.
//   - Else -> HOLD.
// - COUNT: wait_n=0; cnt decrements each clk.
//   - cnt==1 and slow_sel: next clk -> SLOW_WAIT, wait_n stays 0.
//   - cnt==1 and not slow_sel: next clk -> HOLD, wait_n=1.
//   - wait_n is low for exactly N clks.
// - SLOW_WAIT: slow_req=1, wait_n=0; tmo counter loads TMO_CYCLES on entry and decrements each clk.
//   - slow_ack=1 -> HOLD next clk; slow_req=0, wait_n=1.
//   - tmo reaches 0 without ack -> HOLD; timeout_flag=1.
//   - ack and expiry in the same clk: ack wins, flag unchanged.
// - HOLD: wait_n=1, slow_req=0. When mreq_n and iorq_n are both high -> IDLE; cycle_active=0 next clk.
// - Abort: both strobes high in COUNT or SLOW_WAIT -> IDLE next clk; wait_n=1, slow_req=0, cycle_active=0, flag unchanged.
// - A new start is only accepted in IDLE. No back-to-back overlap: the Z80 always releases strobes between cycles.
// - timeout_flag: set has priority over tmo_clr in the same clk.
// - reset mid-cycle: all outputs to reset values next clk; CPU sees wait_n=1 and proceeds.
// - Counter widths: 4 bits for wait counts (max 15), 8 bits for tmo. Parameters are range-checked at elaboration.
// STRUCTURE
// - Shared include z80_bus_defs.vh:
//   - state encodings ST_IDLE/ST_COUNT/ST_SLOW/ST_HOLD
//   - cycle-type codes CT_M1/CT_MEM/CT_IO/CT_INTA
//   - default port window constants
// - Sub-module z80_cycle_detect: strobe history registers, start pulse, cycle-type encode. Synchronous reset, same clk.
// - FSM, wait counter, tmo counter and flag live in the top.
// TESTING
// - Reset: hold reset 3 clks during mreq_n low -> wait_n=1, slow_req=0, cycle_active=0, flag=0 throughout.
// - M1 fetch, default params: mreq_n,m1_n fall -> wait_n low exactly 1 clk starting 1 clk after start; MEM read -> wait_n never low.
// - IO to 8'h40 -> wait_n low 2 clks, slow_req never high. IO to 8'h6A, ack after 5 clks -> wait_n low 2+5+1 clks, slow_req high 5+1 clks.
// - IO to 8'h69, no ack, TMO_CYCLES=4 -> timeout_flag=1 after 2+4 clks, wait_n=1. tmo_clr pulse -> flag=0 next clk.
// - Ack and expiry in the same clk -> flag stays 0. tmo_clr in the same clk as the set -> flag=1.
// - Abort: iorq_n high during SLOW_WAIT -> IDLE next clk, slow_req=0. Then INTA (iorq_n,m1_n low) at 8'h68 -> 2 waits, no slow_req.

Source files
------------

// File: rtl/z80_wait_state_ctrl_pkg.sv
// Shared types and constants for the Z80 wait-state controller: FSM states,
// bus-cycle type codes, counter widths and the default slow-port window.
package z80_wait_state_ctrl_pkg;

    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned TMO_W     = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_WAITS = (1 << WAIT_W) - 1;
    localparam int unsigned MAX_TMO   = (1 << TMO_W) - 1;

    localparam logic [ADDR_W-1:0] DEF_SLOW_BASE = 8'h68;
    localparam logic [ADDR_W-1:0] DEF_SLOW_MASK = 8'hFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_SLOW,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        CT_M1,
        CT_MEM,
        CT_IO,
        CT_INTA
    } cycle_t;

    // Start event handed from the strobe detector to the sequencer
    typedef struct packed {
        logic   start;
        cycle_t ctype;
    } cycle_evt_t;

    // Wait-state count for a given cycle type; INTA shares the I/O count
    function automatic logic [WAIT_W-1:0] waits_for(
        input cycle_t            ctype,
        input logic [WAIT_W-1:0] m1_waits,
        input logic [WAIT_W-1:0] mem_waits,
        input logic [WAIT_W-1:0] io_waits
    );
        case (ctype)
            CT_M1:   return m1_waits;
            CT_MEM:  return mem_waits;
            default: return io_waits;
        endcase
    endfunction

endpackage

// File: rtl/z80_wait_state_ctrl_cycle_detect.sv
// Strobe history and bus-cycle start detection: a one-clock start pulse on a
// falling MREQ_n/IORQ_n plus the prioritised cycle type of that cycle.
module z80_wait_state_ctrl_cycle_detect
    import z80_wait_state_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       m1_n,
    output cycle_evt_t evt_c
);

    logic mreq_q;
    logic iorq_q;

    // History resets high so a strobe already low at reset release counts as a fall
    always_ff @(posedge clk) begin
        if (reset) begin
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
        end else begin
            mreq_q <= mreq_n;
            iorq_q <= iorq_n;
        end
    end

    always_comb begin
        evt_c       = '{start: 1'b0, ctype: CT_MEM};
        evt_c.start = (!mreq_n && mreq_q) || (!iorq_n && iorq_q);
        if (!iorq_n && !m1_n) begin
            evt_c.ctype = CT_INTA;
        end else if (!mreq_n && !m1_n) begin
            evt_c.ctype = CT_M1;
        end else if (!mreq_n) begin
            evt_c.ctype = CT_MEM;
        end else begin
            evt_c.ctype = CT_IO;
        end
    end

endmodule

// File: rtl/z80_wait_state_ctrl.sv
// Z80 bus-cycle sequencer: drives WAIT_n for programmable per-type wait states
// and holds slow-port I/O cycles until the peripheral acks or a watchdog expires.
module z80_wait_state_ctrl
    import z80_wait_state_ctrl_pkg::*;
#(
    parameter int unsigned       M1_WAITS   = 1,
    parameter int unsigned       MEM_WAITS  = 0,
    parameter int unsigned       IO_WAITS   = 2,
    parameter logic [ADDR_W-1:0] SLOW_BASE  = DEF_SLOW_BASE,
    parameter logic [ADDR_W-1:0] SLOW_MASK  = DEF_SLOW_MASK,
    parameter int unsigned       TMO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic              slow_ack,
    input  logic              tmo_clr,
    output logic              wait_n,
    output logic              slow_req,
    output logic              cycle_active,
    output logic              timeout_flag
);

    if (M1_WAITS > MAX_WAITS || MEM_WAITS > MAX_WAITS || IO_WAITS > MAX_WAITS ||
        TMO_CYCLES < 1 || TMO_CYCLES > MAX_TMO) begin : g_param_check
        $error("z80_wait_state_ctrl: wait counts must be 0..15 and TMO_CYCLES 1..255");
    end

    cycle_evt_t        evt_c;
    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [TMO_W-1:0]  tmo;
    logic              slow_sel;
    logic [WAIT_W-1:0] start_waits_c;
    logic              start_slow_c;
    logic              release_c;

    z80_wait_state_ctrl_cycle_detect u_detect (
        .clk    (clk),
        .reset  (reset),
        .mreq_n (mreq_n),
        .iorq_n (iorq_n),
        .m1_n   (m1_n),
        .evt_c  (evt_c)
    );

    // Per-cycle decode at the start pulse; INTA never enters the slow path
    always_comb begin
        start_waits_c = waits_for(evt_c.ctype, WAIT_W'(M1_WAITS), WAIT_W'(MEM_WAITS),
                                  WAIT_W'(IO_WAITS));
        start_slow_c  = (evt_c.ctype == CT_IO) && ((io_addr & SLOW_MASK) == SLOW_BASE);
        release_c     = mreq_n && iorq_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_n       <= 1'b1;
            slow_req     <= 1'b0;
            cycle_active <= 1'b0;
            timeout_flag <= 1'b0;
            cnt          <= '0;
            tmo          <= '0;
            slow_sel     <= 1'b0;
        end else begin
            // A timeout set later in this block overrides the clear
            if (tmo_clr) begin
                timeout_flag <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (evt_c.start) begin
                        cycle_active <= 1'b1;
                        slow_sel     <= start_slow_c;
                        if (start_waits_c != '0) begin
                            state  <= ST_COUNT;
                            cnt    <= start_waits_c;
                            wait_n <= 1'b0;
                        end else if (start_slow_c) begin
                            state    <= ST_SLOW;
                            tmo      <= TMO_W'(TMO_CYCLES);
                            slow_req <= 1'b1;
                            wait_n   <= 1'b0;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_COUNT: begin
                    if (release_c) begin
                        state        <= ST_IDLE;
                        wait_n       <= 1'b1;
                        slow_req     <= 1'b0;
                        cycle_active <= 1'b0;
                        cnt          <= '0;
                    end else if (cnt == WAIT_W'(1)) begin
                        cnt <= '0;
                        if (slow_sel) begin
                            state    <= ST_SLOW;
                            tmo      <= TMO_W'(TMO_CYCLES);
                            slow_req <= 1'b1;
                        end else begin
                            state  <= ST_HOLD;
                            wait_n <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                ST_SLOW: begin
                    if (release_c) begin
                        state        <= ST_IDLE;
                        wait_n       <= 1'b1;
                        slow_req     <= 1'b0;
                        cycle_active <= 1'b0;
                    end else if (slow_ack) begin
                        state    <= ST_HOLD;
                        wait_n   <= 1'b1;
                        slow_req <= 1'b0;
                    end else if (tmo == TMO_W'(1)) begin
                        state        <= ST_HOLD;
                        wait_n       <= 1'b1;
                        slow_req     <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        tmo <= tmo - TMO_W'(1);
                    end
                end
                ST_HOLD: begin
                    wait_n   <= 1'b1;
                    slow_req <= 1'b0;
                    if (release_c) begin
                        state        <= ST_IDLE;
                        cycle_active <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_wait_state_ctrl.sv
// Bench for z80_wait_state_ctrl: two instances (default watchdog and a 4-clock
// watchdog) share the bus stimulus and are checked against per-cycle timing rules.
module tb_z80_wait_state_ctrl;

    localparam int TMO_A = 255;
    localparam int TMO_B = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       mreq_n;
    logic       iorq_n;
    logic       m1_n;
    logic [7:0] io_addr;
    logic       slow_ack;
    logic       tmo_clr;
    logic       wait_n_a, slow_req_a, cycle_active_a, timeout_flag_a;
    logic       wait_n_b, slow_req_b, cycle_active_b, timeout_flag_b;

    int checks   = 0;
    int failures = 0;
    bit flag_a   = 1'b0;
    bit flag_b   = 1'b0;

    always #5 clk = ~clk;

    z80_wait_state_ctrl dut_a (
        .clk          (clk),
        .reset        (reset),
        .mreq_n       (mreq_n),
        .iorq_n       (iorq_n),
        .m1_n         (m1_n),
        .io_addr      (io_addr),
        .slow_ack     (slow_ack),
        .tmo_clr      (tmo_clr),
        .wait_n       (wait_n_a),
        .slow_req     (slow_req_a),
        .cycle_active (cycle_active_a),
        .timeout_flag (timeout_flag_a)
    );

    z80_wait_state_ctrl #(.TMO_CYCLES(TMO_B)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .mreq_n       (mreq_n),
        .iorq_n       (iorq_n),
        .m1_n         (m1_n),
        .io_addr      (io_addr),
        .slow_ack     (slow_ack),
        .tmo_clr      (tmo_clr),
        .wait_n       (wait_n_b),
        .slow_req     (slow_req_b),
        .cycle_active (cycle_active_b),
        .timeout_flag (timeout_flag_b)
    );

    task automatic chk(input string tag, input int step, input logic obs, input bit exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input int step);
        chk("rst_wait_a", step, wait_n_a, 1'b1);
        chk("rst_slow_a", step, slow_req_a, 1'b0);
        chk("rst_act_a", step, cycle_active_a, 1'b0);
        chk("rst_flag_a", step, timeout_flag_a, 1'b0);
        chk("rst_wait_b", step, wait_n_b, 1'b1);
        chk("rst_slow_b", step, slow_req_b, 1'b0);
        chk("rst_act_b", step, cycle_active_b, 1'b0);
        chk("rst_flag_b", step, timeout_flag_b, 1'b0);
    endtask

    // One bus cycle. kind: 0=M1 fetch, 1=memory, 2=I/O, 3=INTA.
    // Step j drives inputs seen at clock edge j and checks the outputs after it.
    // Strobes are low for steps 0..rel_r-1; slow_ack rises at edge waits+ack_k.
    task automatic txn(input int kind, input logic [7:0] addr, input int ack_k,
                       input int rel_r, input int clr_step, input int gap);
        int n, s_a, s_b, e_a, e_b;
        bit slow, to_a, to_b, low;
        n    = (kind == 0) ? 1 : (kind == 1) ? 0 : 2;
        slow = (kind == 2) && ((addr & 8'hFC) == 8'h68);
        s_a  = slow ? ((ack_k < TMO_A) ? ack_k : TMO_A) : 0;
        s_b  = slow ? ((ack_k < TMO_B) ? ack_k : TMO_B) : 0;
        to_a = slow && (ack_k > TMO_A) && (rel_r > n + TMO_A);
        to_b = slow && (ack_k > TMO_B) && (rel_r > n + TMO_B);
        e_a  = (n + s_a < rel_r) ? n + s_a : rel_r;
        e_b  = (n + s_b < rel_r) ? n + s_b : rel_r;
        for (int j = 0; j <= rel_r + gap; j++) begin
            low      = (j < rel_r);
            mreq_n   = !(low && kind <= 1);
            iorq_n   = !(low && kind >= 2);
            m1_n     = !(low && (kind == 0 || kind == 3));
            io_addr  = addr;
            slow_ack = low && (j >= n + ack_k);
            tmo_clr  = (j == clr_step);
            @(posedge clk);
            #1;
            if (to_a && j == n + TMO_A) flag_a = 1'b1;
            else if (j == clr_step)     flag_a = 1'b0;
            if (to_b && j == n + TMO_B) flag_b = 1'b1;
            else if (j == clr_step)     flag_b = 1'b0;
            chk("wait_a", j, wait_n_a, !(j < e_a));
            chk("slow_a", j, slow_req_a, (j >= n) && (j < e_a));
            chk("act_a", j, cycle_active_a, low);
            chk("flag_a", j, timeout_flag_a, flag_a);
            chk("wait_b", j, wait_n_b, !(j < e_b));
            chk("slow_b", j, slow_req_b, (j >= n) && (j < e_b));
            chk("act_b", j, cycle_active_b, low);
            chk("flag_b", j, timeout_flag_b, flag_b);
        end
        slow_ack = 1'b0;
        tmo_clr  = 1'b0;
    endtask

    initial begin
        int kind, ack_k, rel_r, clr_step, n, base;
        logic [7:0] addr;
        logic [7:0] addr_pool [6];
        addr_pool[0] = 8'h40; addr_pool[1] = 8'h68; addr_pool[2] = 8'h6B;
        addr_pool[3] = 8'h6C; addr_pool[4] = 8'h67; addr_pool[5] = 8'hE9;

        // Reset held for three clocks while MREQ_n is low
        reset = 1'b1; mreq_n = 1'b0; iorq_n = 1'b1; m1_n = 1'b1;
        io_addr = 8'h00; slow_ack = 1'b0; tmo_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_idle_reset(i);
        end
        mreq_n = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        txn(0, 8'h00, 99, 4, -1, 1);    // M1 fetch: one wait
        txn(1, 8'h00, 99, 3, -1, 1);    // memory read: no waits
        txn(2, 8'h40, 99, 5, -1, 1);    // fast I/O: two waits
        txn(2, 8'h6A, 6, 11, -1, 1);    // slow I/O, ack after 5 slow clocks; B times out
        txn(1, 8'h00, 99, 3, 1, 1);     // tmo_clr pulse clears B's flag
        txn(2, 8'h69, 4, 9, -1, 1);     // ack in the same clock as B's expiry
        txn(2, 8'h69, 10, 15, 6, 1);    // tmo_clr in the same clock as B's set
        txn(2, 8'h6A, 50, 4, -1, 1);    // abort during slow wait
        txn(3, 8'h68, 99, 5, -1, 1);    // INTA at a slow port address: not slow

        // Reset in the middle of a slow cycle
        mreq_n = 1'b1; iorq_n = 1'b0; m1_n = 1'b1; io_addr = 8'h69;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        flag_a = 1'b0;
        flag_b = 1'b0;
        chk_idle_reset(100);
        iorq_n = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        txn(1, 8'h00, 99, 2, -1, 1);

        // Randomised cycles, mostly complete, some aborted early
        for (int t = 0; t < 60; t++) begin
            kind  = int'($urandom_range(0, 3));
            addr  = addr_pool[$urandom_range(0, 5)];
            ack_k = int'($urandom_range(1, 8));
            n     = (kind == 0) ? 1 : (kind == 1) ? 0 : 2;
            base  = n + (((kind == 2) && ((addr & 8'hFC) == 8'h68)) ? ack_k : 0);
            if (base > 0 && $urandom_range(0, 3) == 0)
                rel_r = int'($urandom_range(1, base));
            else
                rel_r = base + int'($urandom_range(1, 3));
            clr_step = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rel_r)) : -1;
            txn(kind, addr, ack_k, rel_r, clr_step, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
